// File: rtl/xmpl_cic_dec.sv
// Hogenauer CIC decimator: N_STAGES chained integrators at the input rate, pipelined combs at
// the decimated rate, then a live shift, saturation and a single-entry valid/ready output holder.
module xmpl_cic_dec #(
  parameter int N_STAGES = 3,
  parameter int R_MAX    = 16,
  parameter int IN_W     = 12,
  parameter int OUT_W    = 16,
  localparam int RW      = $clog2(R_MAX) + 1,
  localparam int ACC_W   = IN_W + N_STAGES * $clog2(R_MAX),
  localparam int SW      = $clog2(ACC_W)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cfg_en_i,
  input  logic [RW-1:0]           cfg_rate_i,
  input  logic [SW-1:0]           cfg_shift_i,
  input  logic                    cfg_clr_i,
  input  logic                    in_valid_i,
  input  logic signed [IN_W-1:0]  in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [OUT_W-1:0] out_data_o,
  output logic                    ovr_o,
  output logic                    sat_o
);

  logic             flush;
  logic [RW-1:0]    rate_q;
  logic [RW-1:0]    rate_clamped;
  logic [RW-1:0]    cnt;
  logic             beat_done;
  logic [N_STAGES+1:0] stb;
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W-1:0] comb_last;
  logic [SW-1:0]    sh_eff;
  logic signed [ACC_W-1:0] shifted;
  logic             sat_now;
  logic signed [OUT_W-1:0] sat_val;
  logic signed [OUT_W-1:0] res;
  logic             res_sat;
  logic             ovr_set;
  logic             sat_set;

  assign flush     = reset_i || !cfg_en_i;
  assign in_ext    = {{(ACC_W-IN_W){in_data_i[IN_W-1]}}, in_data_i};
  assign beat_done = in_valid_i && (cnt == rate_q - 1'b1);

  always_comb begin
    rate_clamped = cfg_rate_i;
    if (cfg_rate_i <= RW'(1))
      rate_clamped = RW'(1);
    else if (cfg_rate_i > RW'(R_MAX))
      rate_clamped = RW'(R_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      rate_q <= RW'(1);
    else if (!cfg_en_i)
      rate_q <= rate_clamped;
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      cnt <= '0;
      stb <= '0;
    end else begin
      stb <= {stb[N_STAGES:0], beat_done};
      if (in_valid_i)
        cnt <= beat_done ? '0 : cnt + 1'b1;
    end
  end

  // Each integrator adds the freshly updated value of the stage before it, so the chain
  // forms an N-fold running sum with no extra sample delay between stages.
  for (genvar i = 0; i < N_STAGES; i++) begin : g_int
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prev;
    logic [ACC_W-1:0] sum;
    if (i == 0) begin : g_first
      assign prev = in_ext;
    end else begin : g_rest
      assign prev = g_int[i-1].sum;
    end
    assign sum = acc + prev;
    always_ff @(posedge clk_i) begin
      if (flush)
        acc <= '0;
      else if (in_valid_i)
        acc <= sum;
    end
  end

  // Comb stage i fires one cycle after stage i-1 for the same decimated sample.
  for (genvar i = 0; i < N_STAGES; i++) begin : g_comb
    logic [ACC_W-1:0] cval;
    logic [ACC_W-1:0] dval;
    logic [ACC_W-1:0] din;
    if (i == 0) begin : g_first
      assign din = g_int[N_STAGES-1].acc;
    end else begin : g_rest
      assign din = g_comb[i-1].cval;
    end
    always_ff @(posedge clk_i) begin
      if (flush) begin
        cval <= '0;
        dval <= '0;
      end else if (stb[i]) begin
        cval <= din - dval;
        dval <= din;
      end
    end
  end

  assign comb_last = g_comb[N_STAGES-1].cval;
  assign sh_eff    = ({1'b0, cfg_shift_i} >= (SW+1)'(ACC_W)) ? SW'(ACC_W-1) : cfg_shift_i;
  assign shifted   = $signed(comb_last) >>> sh_eff;
  assign sat_now   = !((&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1]));

  always_comb begin
    sat_val = shifted[OUT_W-1:0];
    if (sat_now)
      sat_val = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      res     <= '0;
      res_sat <= 1'b0;
    end else if (stb[N_STAGES]) begin
      res     <= sat_val;
      res_sat <= sat_now;
    end
  end

  assign ovr_set = cfg_en_i && stb[N_STAGES+1] && out_valid_o && !out_ready_i;
  assign sat_set = cfg_en_i && stb[N_STAGES+1] && res_sat;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      ovr_o       <= 1'b0;
      sat_o       <= 1'b0;
    end else begin
      ovr_o <= (ovr_o && !cfg_clr_i) || ovr_set;
      sat_o <= (sat_o && !cfg_clr_i) || sat_set;
      if (!cfg_en_i) begin
        out_valid_o <= 1'b0;
      end else if (stb[N_STAGES+1]) begin
        // A held, unaccepted result wins over the newcomer.
        if (!(out_valid_o && !out_ready_i)) begin
          out_valid_o <= 1'b1;
          out_data_o  <= res;
        end
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xmpl_cic_dec.sv
// Bench for xmpl_cic_dec: expected outputs come from a direct convolution with the CIC
// impulse response (boxcar of length R convolved N times), sampled every R-th accepted beat.
module tb_xmpl_cic_dec;
  localparam int N    = 3;
  localparam int RMAX = 16;
  localparam int AW   = 24;
  localparam int LAT  = N + 2;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic rst, en, clr, vin, rdy;
  logic [4:0] rate, shift;
  logic signed [11:0] din;
  logic out_valid, ovr, sat;
  logic signed [15:0] out_data;

  xmpl_cic_dec #(.N_STAGES(N), .R_MAX(RMAX), .IN_W(12), .OUT_W(16)) dut (
    .clk_i(clk_i), .reset_i(rst), .cfg_en_i(en), .cfg_rate_i(rate), .cfg_shift_i(shift),
    .cfg_clr_i(clr), .in_valid_i(vin), .in_data_i(din), .out_valid_o(out_valid),
    .out_ready_i(rdy), .out_data_o(out_data), .ovr_o(ovr), .sat_o(sat)
  );

  typedef struct {int due; int val; bit sat;} pend_t;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int hist[$];
  pend_t pq[$];
  int hcoef[64];
  int hlen;
  int r_m;
  logic vm, ovr_m, sat_m;
  logic signed [15:0] od_m;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int clamp_r(input int v);
    if (v <= 1) return 1;
    if (v > RMAX) return RMAX;
    return v;
  endfunction

  function automatic void build_h(input int r);
    int nxt[64];
    hcoef = '{default: 0};
    hcoef[0] = 1;
    hlen = 1;
    for (int s = 0; s < N; s++) begin
      nxt = '{default: 0};
      for (int k = 0; k < hlen + r - 1; k++)
        for (int j = 0; j < r; j++)
          if (k - j >= 0 && k - j < hlen) nxt[k] += hcoef[k-j];
      hcoef = nxt;
      hlen = hlen + r - 1;
    end
  endfunction

  function automatic pend_t make_result(input int b);
    pend_t p;
    longint y, ys;
    logic signed [AW-1:0] y24;
    int sh;
    build_h(r_m);
    y = 0;
    for (int k = 0; k < hlen; k++)
      if (b - k >= 0) y += longint'(hcoef[k]) * longint'(hist[b-k]);
    y24 = y[AW-1:0];
    sh = (int'(shift) >= AW) ? AW - 1 : int'(shift);
    ys = longint'(y24) >>> sh;
    p.due = edge_n + LAT;
    p.sat = 1'b0;
    if (ys > 32767) begin ys = 32767; p.sat = 1'b1; end
    else if (ys < -32768) begin ys = -32768; p.sat = 1'b1; end
    p.val = int'(ys);
    return p;
  endfunction

  task automatic model_edge();
    bit ovr_s, sat_s;
    int b;
    if (rst) begin
      vm = 0; od_m = 0; ovr_m = 0; sat_m = 0; r_m = 1;
      hist.delete(); pq.delete();
      return;
    end
    ovr_s = 0; sat_s = 0;
    if (!en) begin
      vm = 0;
      hist.delete(); pq.delete();
      r_m = clamp_r(int'(rate));
    end else begin
      if (pq.size() > 0 && pq[0].due == edge_n) begin
        sat_s = pq[0].sat;
        if (vm && !rdy) ovr_s = 1;
        else begin vm = 1; od_m = 16'(pq[0].val); end
        pq.delete(0);
      end else if (vm && rdy) begin
        vm = 0;
      end
      if (vin) begin
        hist.push_back(int'(din));
        b = hist.size() - 1;
        if (b % r_m == r_m - 1) pq.push_back(make_result(b));
      end
    end
    ovr_m = (ovr_m && !clr) || ovr_s;
    sat_m = (sat_m && !clr) || sat_s;
  endtask

  task automatic tick();
    @(posedge clk_i);
    edge_n++;
    model_edge();
    #1;
    chk("valid", longint'(out_valid), longint'(vm));
    chk("data", longint'(out_data), longint'(od_m));
    chk("ovr", longint'(ovr), longint'(ovr_m));
    chk("sat", longint'(sat), longint'(sat_m));
  endtask

  task automatic beats(input int n, input int d);
    for (int i = 0; i < n; i++) begin
      vin = 1; din = 12'(d);
      tick();
    end
    vin = 0;
  endtask

  task automatic configure(input int r, input int s);
    en = 0; rate = 5'(r); shift = 5'(s);
    tick();
    en = 1;
  endtask

  task automatic measure(input string tag, input int exp);
    int t;
    t = 0;
    vin = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    chk(tag, t, exp);
  endtask

  initial begin
    rst = 1; en = 0; clr = 0; vin = 0; rdy = 1; rate = 0; shift = 0; din = 0;
    tick(); tick();
    chk("rst_valid", longint'(out_valid), 0);
    rst = 0;

    // DC 100, R=8, shift 9
    configure(8, 9);
    beats(80, 100);
    chk("dc100_data", longint'(out_data), 100);
    chk("dc100_sat", longint'(sat), 0);

    // same input, no shift: saturates; clear while saturation keeps recurring
    configure(8, 0);
    beats(40, 100);
    chk("sat_data", longint'(out_data), 32767);
    chk("sat_flag", longint'(sat), 1);
    clr = 1; vin = 1; din = 12'(100);
    tick();
    clr = 0;
    beats(12, 100);
    chk("sat_again", longint'(sat), 1);

    // full-scale negative DC at maximum ratio
    configure(16, 12);
    beats(120, -2048);
    chk("neg_data", longint'(out_data), -2048);

    // backpressure across two results
    configure(4, 4);
    rdy = 0;
    for (int i = 0; i < 12; i++) begin
      vin = 1; din = 12'($urandom_range(0, 4095));
      tick();
    end
    vin = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("ovr_flag", longint'(ovr), 1);
    chk("held_valid", longint'(out_valid), 1);
    rdy = 1;
    tick();
    chk("one_xfer", longint'(out_valid), 0);
    clr = 1;
    tick();
    clr = 0;
    chk("ovr_clr", longint'(ovr), 0);

    // latency at R=4, rate change while enabled ignored
    configure(4, 6);
    rate = 5'd2;
    for (int i = 0; i < 40; i++) begin
      vin = 1; din = 12'($urandom_range(0, 4095));
      tick();
    end
    vin = 0;
    for (int i = 0; i < 10; i++) tick();
    configure(4, 6);
    beats(4, 300);
    measure("latency_r4", LAT);

    // reset two beats into a period
    beats(2, 500);
    rst = 1;
    tick();
    chk("rst_mid_valid", longint'(out_valid), 0);
    chk("rst_mid_data", longint'(out_data), 0);
    rst = 0;
    configure(4, 6);
    beats(3, 500);
    chk("no_early_out", longint'(out_valid), 0);
    beats(1, 500);
    measure("latency_after_rst", LAT);

    // randomized sessions
    for (int s = 0; s < 8; s++) begin
      configure(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      for (int i = 0; i < 150; i++) begin
        vin = ($urandom_range(0, 3) != 0);
        din = 12'($urandom_range(0, 4095));
        rdy = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 31) == 0);
        tick();
      end
      vin = 0; clr = 0; rdy = 1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
